ysyx_25060170_mem_arbiter: RTL and testbench
============================================

Name: ysyx_25060170_mem_arbiter

Overview:
- Shares one memory port between two requesters: instruction fetch (IFU, read-only, master 0) and load/store (LSU, read/write, master 1).
- Sits between IFU/LSU and the memory model, so the core can move off the combinational single-cycle MEM path.
- Allows one outstanding transaction at a time.
- Round-robin arbitration and a response-timeout watchdog that returns an error instead of hanging the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum cycles from slave request issue to response; range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- if_req_valid  in  1  IFU read request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  ADDR_W  IFU address
- if_resp_valid  out  1  IFU response pulse
- if_resp_err  out  1  IFU response is a timeout error
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  ADDR_W  LSU address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_W  write data
- ls_wmask  in  DATA_W/8  byte-enable mask
- ls_resp_valid  out  1  LSU response pulse
- ls_resp_err  out  1  LSU response is a timeout error
- resp_rdata  out  DATA_W  read data, shared by both masters
- s_req_valid  out  1  request to memory
- s_req_ready  in  1  memory accepts request
- s_addr  out  ADDR_W  memory address
- s_wen  out  1  memory write enable
- s_wdata  out  DATA_W  memory write data
- s_wmask  out  DATA_W/8  memory byte mask
- s_resp_valid  in  1  memory response valid
- s_rdata  in  DATA_W  memory read data

Behaviour:
- Reset, while rst = 0, asynchronous:
  - state = IDLE, last_grant = 0 (IFU), timeout counter = 0.
  - All s_* outputs = 0.
  - All resp_valid / resp_err = 0, resp_rdata = 0.
  - Reset mid-transaction aborts it silently; no response is issued.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Selection is combinational from the valid inputs.
  - Only one valid: that master is selected.
  - Both valid: the master NOT equal to last_grant is selected (round-robin).
  - The selected master's req_ready = 1 in that cycle; the other's ready = 0.
  - On that edge: latch addr, wen, wdata, wmask and owner; wen = 0 and wmask = 0 when the owner is IFU. Set last_grant = owner, counter = 0, go to REQ.
  - Neither valid: stay in IDLE.
- REQ:
  - s_req_valid = 1; s_* driven from the latched registers.
  - s_req_ready = 1 -> RESP. Otherwise stay.
- RESP:
  - s_req_valid = 0.
  - s_resp_valid = 1 -> register s_rdata into resp_rdata, go to DONE with err = 0.
  - s_rdata is captured for writes too; masters ignore it.
- Watchdog:
  - Counter increments every cycle in REQ or RESP and saturates.
  - When it reaches TIMEOUT without completion -> DONE with err = 1, resp_rdata = 0, s_req_valid dropped.
  - If s_resp_valid and the timeout coincide, the response wins (err = 0).
- DONE, exactly one cycle:
  - The owner's resp_valid = 1 and resp_err = err; the other master sees 0. Then go to IDLE.
  - Masters must accept the response; there is no back-pressure.
- Ready signals are 0 in REQ, RESP and DONE.
- Minimum latency, request accept to resp_valid: 3 cycles (IDLE -> REQ -> RESP -> DONE), assuming s_req_ready and s_resp_valid are each asserted in their first cycle.
- Back-to-back:
  - The next request is accepted in the IDLE cycle after DONE.
  - Sustained throughput is one transaction per 4 cycles.
- s_resp_valid outside RESP (e.g., a late response after a timeout) is ignored.
- All outputs are registered or decoded from state/latched registers, except if_req_ready and ls_req_ready, which are combinational on the valid inputs in IDLE.

Test Plan:
- IFU only: if_addr = 0x80000000; memory ready and resp immediate, s_rdata = 0x00100073 -> if_req_ready in cycle 0, s_req_valid in cycle 1, if_resp_valid = 1 with resp_rdata = 0x00100073 in cycle 3, if_resp_err = 0.
- Simultaneous requests after reset (last_grant = IFU): both valid -> LSU granted first. IFU held valid -> IFU granted in the next IDLE. Both held again -> LSU granted (strict alternation observed over 6 grants).
- LSU write: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, s_req_ready stalled 4 cycles -> s_req_valid stays high with stable payload for 5 cycles, then ls_resp_valid pulses exactly once, 2 cycles after the handshake, when memory responds immediately.
- Timeout: TIMEOUT = 8, memory never responds -> ls_resp_valid = 1 with ls_resp_err = 1 and resp_rdata = 0, 9 cycles after grant. A late s_resp_valid in IDLE produces no response.
- Reset mid-RESP: drop rst for 1 cycle -> all outputs 0 immediately (asynchronous), no resp_valid pulse; a fresh IFU request afterwards completes normally.
- Response/timeout coincidence: s_resp_valid asserted in the same cycle the counter hits TIMEOUT -> resp_err = 0 and resp_rdata = s_rdata.

Source files
------------

// File: rtl/ysyx_25060170_mem_arbiter.sv
// Two-master memory arbiter: IFU (master 0, read-only) and LSU (master 1, read/write)
// share one memory port, one outstanding transaction, round-robin grant, response watchdog.
module ysyx_25060170_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic                if_resp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic                ls_resp_err,

    output logic [DATA_W-1:0]   resp_rdata,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_err;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grant;
    logic              w_sel_ls;
    logic [16:0]       w_cnt_inc;
    logic              w_timeout;
    logic              w_busy;

    // Round-robin selection: on contention the master that did not win last time goes next.
    always_comb begin
        w_sel_ls = 1'b0;
        if (ls_req_valid && (!if_req_valid || (r_last_grant == 1'b0))) begin
            w_sel_ls = 1'b1;
        end else begin
            w_sel_ls = 1'b0;
        end
    end

    assign w_grant      = (r_state == IDLE) && (if_req_valid || ls_req_valid);
    assign if_req_ready = w_grant && !w_sel_ls;
    assign ls_req_ready = w_grant && w_sel_ls;

    // The watchdog fires on the edge where the counter would reach TIMEOUT.
    assign w_busy    = (r_state == REQ) || (r_state == RESP);
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_timeout = w_busy && (w_cnt_inc >= 17'(TIMEOUT));

    // Transaction FSM, payload latch, watchdog counter and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= 16'd0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_busy && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= r_cnt;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_sel_ls;
                        r_last_grant <= w_sel_ls;
                        r_err        <= 1'b0;
                        r_cnt        <= 16'd0;
                        r_state      <= REQ;
                        if (w_sel_ls) begin
                            r_addr  <= ls_addr;
                            r_wen   <= ls_wen;
                            r_wdata <= ls_wdata;
                            r_wmask <= ls_wmask;
                        end else begin
                            r_addr  <= if_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else if (s_req_ready) begin
                        r_state <= RESP;
                    end else begin
                        r_state <= REQ;
                    end
                end
                RESP: begin
                    // A real response beats a watchdog expiry in the same cycle.
                    if (s_resp_valid) begin
                        r_err   <= 1'b0;
                        r_rdata <= s_rdata;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_req_valid   = (r_state == REQ);
    assign s_addr        = r_addr;
    assign s_wen         = r_wen;
    assign s_wdata       = r_wdata;
    assign s_wmask       = r_wmask;

    assign if_resp_valid = (r_state == DONE) && !r_owner;
    assign if_resp_err   = (r_state == DONE) && !r_owner && r_err;
    assign ls_resp_valid = (r_state == DONE) && r_owner;
    assign ls_resp_err   = (r_state == DONE) && r_owner && r_err;
    assign resp_rdata    = r_rdata;

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Directed bench for ysyx_25060170_mem_arbiter (TIMEOUT = 8); memory side is driven by hand.
module tb_ysyx_25060170_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [31:0] if_addr;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_wmask;
    logic [31:0] resp_rdata;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_25060170_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_err(ls_resp_err),
        .resp_rdata(resp_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'h0;
        ls_req_valid = 1'b0; ls_addr = 32'h0; ls_wen = 1'b0; ls_wdata = 32'h0; ls_wmask = 4'h0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_s_req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_resp_valid", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // IFU only, immediate memory
        if_req_valid = 1'b1; if_addr = 32'h8000_0000;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; s_rdata = 32'h0010_0073;
        #1;
        chk("t1_if_ready_c0", {31'd0, if_req_ready}, 32'd1);
        chk("t1_ls_ready_c0", {31'd0, ls_req_ready}, 32'd0);
        chk("t1_s_valid_c0", {31'd0, s_req_valid}, 32'd0);
        tick();
        if_req_valid = 1'b0;
        chk("t1_s_valid_c1", {31'd0, s_req_valid}, 32'd1);
        chk("t1_s_addr_c1", s_addr, 32'h8000_0000);
        chk("t1_s_wen_mask_c1", {27'd0, s_wen, s_wmask}, 32'd0);
        tick();
        chk("t1_s_valid_c2", {31'd0, s_req_valid}, 32'd0);
        chk("t1_if_resp_c2", {31'd0, if_resp_valid}, 32'd0);
        tick();
        chk("t1_if_resp_c3", {31'd0, if_resp_valid}, 32'd1);
        chk("t1_if_err_c3", {31'd0, if_resp_err}, 32'd0);
        chk("t1_rdata_c3", resp_rdata, 32'h0010_0073);
        chk("t1_ls_resp_c3", {31'd0, ls_resp_valid}, 32'd0);
        tick();
        chk("t1_if_resp_c4", {31'd0, if_resp_valid}, 32'd0);

        // Simultaneous requests: strict alternation starting with LSU
        if_req_valid = 1'b1; if_addr = 32'h8000_0010;
        ls_req_valid = 1'b1; ls_addr = 32'h8000_0020; ls_wen = 1'b0;
        s_rdata = 32'h0000_00AA;
        for (int i = 0; i < 6; i++) begin
            logic exp_ls;
            exp_ls = ((i % 2) == 0);
            #1;
            chk("t2_ls_ready", {31'd0, ls_req_ready}, {31'd0, exp_ls});
            chk("t2_if_ready", {31'd0, if_req_ready}, {31'd0, !exp_ls});
            tick(); tick(); tick();
            chk("t2_ls_resp", {31'd0, ls_resp_valid}, {31'd0, exp_ls});
            chk("t2_if_resp", {31'd0, if_resp_valid}, {31'd0, !exp_ls});
            chk("t2_rdata", resp_rdata, 32'h0000_00AA);
            tick();
        end

        // LSU write with a 4-cycle request stall
        if_req_valid = 1'b0;
        ls_req_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b1;
        ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = 32'hCAFE_F00D;
        #1;
        chk("t3_ls_ready_c0", {31'd0, ls_req_ready}, 32'd1);
        chk("t3_if_ready_c0", {31'd0, if_req_ready}, 32'd0);
        tick();
        ls_req_valid = 1'b0; ls_wen = 1'b0; ls_wdata = 32'h0; ls_wmask = 4'h0; ls_addr = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_stall_valid", {31'd0, s_req_valid}, 32'd1);
            chk("t3_stall_addr", s_addr, 32'h8000_1000);
            chk("t3_stall_wdata", s_wdata, 32'hDEAD_BEEF);
            chk("t3_stall_wen_mask", {27'd0, s_wen, s_wmask}, 32'h0000_001F);
            chk("t3_stall_no_resp", {31'd0, ls_resp_valid}, 32'd0);
            tick();
        end
        s_req_ready = 1'b1;
        chk("t3_valid_c5", {31'd0, s_req_valid}, 32'd1);
        tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b1;
        chk("t3_valid_c6", {31'd0, s_req_valid}, 32'd0);
        chk("t3_ls_resp_c6", {31'd0, ls_resp_valid}, 32'd0);
        tick();
        s_resp_valid = 1'b0;
        chk("t3_ls_resp_c7", {31'd0, ls_resp_valid}, 32'd1);
        chk("t3_ls_err_c7", {31'd0, ls_resp_err}, 32'd0);
        chk("t3_if_resp_c7", {31'd0, if_resp_valid}, 32'd0);
        tick();
        chk("t3_ls_resp_c8", {31'd0, ls_resp_valid}, 32'd0);

        // Timeout: memory accepts but never responds
        ls_req_valid = 1'b1; ls_addr = 32'h8000_2000; ls_wen = 1'b0;
        s_req_ready = 1'b1; s_resp_valid = 1'b0; s_rdata = 32'h1234_5678;
        #1;
        chk("t4_ls_ready_c0", {31'd0, ls_req_ready}, 32'd1);
        tick();
        ls_req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("t4_no_resp_yet", {31'd0, ls_resp_valid}, 32'd0);
            tick();
        end
        chk("t4_ls_resp_c9", {31'd0, ls_resp_valid}, 32'd1);
        chk("t4_ls_err_c9", {31'd0, ls_resp_err}, 32'd1);
        chk("t4_rdata_c9", resp_rdata, 32'h0);
        chk("t4_s_valid_c9", {31'd0, s_req_valid}, 32'd0);
        s_req_ready = 1'b0;
        tick();
        s_resp_valid = 1'b1;
        tick();
        chk("t4_late_ls_resp", {31'd0, ls_resp_valid}, 32'd0);
        chk("t4_late_if_resp", {31'd0, if_resp_valid}, 32'd0);
        chk("t4_late_rdata", resp_rdata, 32'h0);
        s_resp_valid = 1'b0;

        // Reset during RESP aborts the transaction silently
        if_req_valid = 1'b1; if_addr = 32'h8000_0004;
        s_req_ready = 1'b1; s_resp_valid = 1'b0; s_rdata = 32'h1111_1111;
        tick();
        if_req_valid = 1'b0;
        tick();
        chk("t5_addr_before_rst", s_addr, 32'h8000_0004);
        rst = 1'b0;
        #1;
        chk("t5_rst_s_valid", {31'd0, s_req_valid}, 32'd0);
        chk("t5_rst_s_addr", s_addr, 32'h0);
        chk("t5_rst_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
        chk("t5_rst_rdata", resp_rdata, 32'h0);
        s_resp_valid = 1'b1;
        tick();
        chk("t5_rst_edge_resp", {31'd0, if_resp_valid}, 32'd0);
        rst = 1'b1; s_resp_valid = 1'b0;
        tick();
        chk("t5_post_rst_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
        if_req_valid = 1'b1; if_addr = 32'h8000_0008;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; s_rdata = 32'h0000_0013;
        #1;
        chk("t5_fresh_if_ready", {31'd0, if_req_ready}, 32'd1);
        tick();
        if_req_valid = 1'b0;
        tick(); tick();
        chk("t5_fresh_if_resp", {31'd0, if_resp_valid}, 32'd1);
        chk("t5_fresh_if_err", {31'd0, if_resp_err}, 32'd0);
        chk("t5_fresh_rdata", resp_rdata, 32'h0000_0013);
        s_req_ready = 1'b0; s_resp_valid = 1'b0;
        tick();

        // Response arrives in the same cycle the watchdog expires
        ls_req_valid = 1'b1; ls_addr = 32'h8000_3000; ls_wen = 1'b0;
        s_req_ready = 1'b1; s_resp_valid = 1'b0; s_rdata = 32'hA5A5_A5A5;
        tick();
        ls_req_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        s_resp_valid = 1'b1;
        chk("t6_no_resp_c8", {31'd0, ls_resp_valid}, 32'd0);
        tick();
        chk("t6_ls_resp_c9", {31'd0, ls_resp_valid}, 32'd1);
        chk("t6_ls_err_c9", {31'd0, ls_resp_err}, 32'd0);
        chk("t6_rdata_c9", resp_rdata, 32'hA5A5_A5A5);
        s_resp_valid = 1'b0; s_req_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
